// File: rtl/cfg_pkg.sv
// System-level sizing constants shared by the order-book blocks.
package cfg_pkg;
    localparam int EGRESS_QUEUE_DEPTH_N = 4;
endpackage

// File: rtl/ob_pkg.sv
// Order-book shared types: response record, arbiter states and producer ids.
package ob_pkg;
    typedef enum logic {ARB, LOCK} arb_state_t;

    localparam int RSP_SRC_CNTRL   = 0;
    localparam int RSP_SRC_BID_REJ = 1;
    localparam int RSP_SRC_ASK_REJ = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] order_id;
        logic [13:0] qty;
    } rsp_t;
endpackage

// File: rtl/ob_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping mod N.
module ob_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/ob_rsp_arb.sv
// Credit-based round-robin arbiter with burst lock feeding the egress response queue.
module ob_rsp_arb
    import ob_pkg::*;
#(
    parameter int N_SRC    = 3,
    parameter int CREDITS  = cfg_pkg::EGRESS_QUEUE_DEPTH_N,
    parameter int CREDIT_W = $clog2(CREDITS + 1),
    localparam int RSP_W   = $bits(rsp_t),
    localparam int IDX_W   = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_vld,
    input  logic [N_SRC-1:0]       src_lock,
    input  logic [N_SRC*RSP_W-1:0] src_rsp,
    output logic [N_SRC-1:0]       src_ack,
    output logic                   egress_push_r,
    output logic [RSP_W-1:0]       egress_push_data_r,
    input  logic                   egress_pop,
    output logic [CREDIT_W-1:0]    credits_r,
    output logic                   lock_vld_r,
    output logic [IDX_W-1:0]       lock_owner_r,
    output logic                   err_credit_r
);
    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr, rr_nxt, owner_nxt, pick_idx;
    logic [N_SRC-1:0]    req, pick_gnt;
    logic                pick_any, grant;
    logic [CREDIT_W-1:0] credits_nxt;
    logic                err_nxt;

    // While locked only the owner may compete, so the picker result is the owner.
    always_comb begin
        req = src_vld;
        if (state == LOCK) req = src_vld & (N_SRC'(1) << lock_owner_r);
    end

    ob_rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign grant      = rst_n && pick_any && (credits_r != '0);
    assign src_ack    = grant ? pick_gnt : '0;
    assign lock_vld_r = (state == LOCK);

    always_comb begin
        state_nxt = state;
        owner_nxt = lock_owner_r;
        rr_nxt    = rr_ptr;
        if (grant) begin
            rr_nxt = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
            case (state)
                ARB: begin
                    if (src_lock[pick_idx]) begin
                        state_nxt = LOCK;
                        owner_nxt = pick_idx;
                    end
                end
                LOCK: begin
                    if (!src_lock[lock_owner_r]) state_nxt = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    // A pop with the queue already fully credited is an upstream bug: saturate and flag.
    always_comb begin
        credits_nxt = credits_r;
        err_nxt     = err_credit_r;
        if (grant && !egress_pop) begin
            credits_nxt = credits_r - CREDIT_W'(1);
        end else if (!grant && egress_pop) begin
            if (credits_r == CREDIT_W'(CREDITS)) err_nxt = 1'b1;
            else credits_nxt = credits_r + CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ARB;
            rr_ptr             <= '0;
            lock_owner_r       <= '0;
            credits_r          <= CREDIT_W'(CREDITS);
            err_credit_r       <= 1'b0;
            egress_push_r      <= 1'b0;
            egress_push_data_r <= '0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_nxt;
            lock_owner_r  <= owner_nxt;
            credits_r     <= credits_nxt;
            err_credit_r  <= err_nxt;
            egress_push_r <= grant;
            if (grant) egress_push_data_r <= src_rsp[pick_idx*RSP_W +: RSP_W];
        end
    end
endmodule

// File: tb/tb_ob_rsp_arb.sv
// Bench for ob_rsp_arb: directed scenarios plus random traffic against a behavioural model.
module tb_ob_rsp_arb;
    import ob_pkg::*;
    localparam int N  = 3;
    localparam int C  = 4;
    localparam int CW = $clog2(C + 1);
    localparam int RW = $bits(rsp_t);
    localparam int OW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    src_vld = '0;
    logic [N-1:0]    src_lock = '0;
    logic [N*RW-1:0] src_rsp = '0;
    logic [N-1:0]    src_ack;
    logic            egress_push_r;
    logic [RW-1:0]   egress_push_data_r;
    logic            egress_pop = 1'b0;
    logic [CW-1:0]   credits_r;
    logic            lock_vld_r;
    logic [OW-1:0]   lock_owner_r;
    logic            err_credit_r;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ob_rsp_arb dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .src_vld            (src_vld),
        .src_lock           (src_lock),
        .src_rsp            (src_rsp),
        .src_ack            (src_ack),
        .egress_push_r      (egress_push_r),
        .egress_push_data_r (egress_push_data_r),
        .egress_pop         (egress_pop),
        .credits_r          (credits_r),
        .lock_vld_r         (lock_vld_r),
        .lock_owner_r       (lock_owner_r),
        .err_credit_r       (err_credit_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: state after the most recent clock edge, advanced once per cycle.
    int            m_cred = C, m_rr = 0, m_owner = 0, m_g;
    bit            m_lock = 0, m_push = 0, m_err = 0;
    logic [RW-1:0] m_data = '0;
    logic [63:0]   m_ack;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cred = C; m_rr = 0; m_owner = 0; m_lock = 0;
            m_push = 0; m_err = 0; m_data = '0;
        end else begin
            chk("credits", 64'(credits_r), 64'(m_cred));
            chk("push", 64'(egress_push_r), 64'(m_push));
            if (m_push) chk("push_data", 64'(egress_push_data_r), 64'(m_data));
            chk("lock_vld", 64'(lock_vld_r), 64'(m_lock));
            chk("lock_owner", 64'(lock_owner_r), 64'(m_owner));
            chk("err_credit", 64'(err_credit_r), 64'(m_err));
            m_g = -1;
            if (m_cred > 0) begin
                if (m_lock) begin
                    if (src_vld[m_owner]) m_g = m_owner;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (m_g < 0 && src_vld[(m_rr + k) % N]) m_g = (m_rr + k) % N;
                end
            end
            m_ack = '0;
            if (m_g >= 0) m_ack[m_g] = 1'b1;
            chk("ack", 64'(src_ack), m_ack);
            if (m_g < 0 && egress_pop && m_cred == C) m_err = 1;
            else m_cred = m_cred - (m_g >= 0 ? 1 : 0) + (egress_pop ? 1 : 0);
            m_push = (m_g >= 0);
            if (m_g >= 0) begin
                m_data = src_rsp[m_g*RW +: RW];
                m_rr   = (m_g + 1) % N;
                if (!m_lock && src_lock[m_g]) begin
                    m_lock = 1; m_owner = m_g;
                end else if (m_lock && !src_lock[m_g]) begin
                    m_lock = 0;
                end
            end
        end
    end

    task automatic step(output logic [N-1:0] a);
        @(negedge clk);
        a = src_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic new_data(input int i);
        src_rsp[i*RW +: RW] = RW'($urandom);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] seq[4];
        int cnt, done, n;
        int left[N];

        // Reset and idle
        for (int i = 0; i < N; i++) new_data(i);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(a);
            chk("t1_ack", 64'(a), 64'd0);
            chk("t1_credits", 64'(credits_r), 64'd4);
            chk("t1_push", 64'(egress_push_r), 64'd0);
        end

        // Round robin with continuous pops
        src_vld = 3'b111; src_lock = '0; egress_pop = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(a);
            seq[c] = a;
            chk("t2_push_follows", 64'(egress_push_r), 64'd1);
            chk("t2_credits", 64'(credits_r), 64'd4);
        end
        chk("t2_seq0", 64'(seq[0]), 64'b001);
        chk("t2_seq1", 64'(seq[1]), 64'b010);
        chk("t2_seq2", 64'(seq[2]), 64'b100);
        chk("t2_seq3", 64'(seq[3]), 64'b001);
        src_vld = '0; egress_pop = 1'b0;
        step(a);

        // Credit exhaustion and single-credit return
        src_vld = 3'b001; cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(a);
            if (a == 3'b001) cnt++;
        end
        chk("t3_ack_count", 64'(cnt), 64'd4);
        chk("t3_credits_zero", 64'(credits_r), 64'd0);
        egress_pop = 1'b1;
        step(a);
        chk("t3_no_ack_at_zero", 64'(a), 64'd0);
        chk("t3_credit_back", 64'(credits_r), 64'd1);
        egress_pop = 1'b0;
        step(a);
        chk("t3_ack_after_pop", 64'(a), 64'b001);
        src_vld = '0;
        for (int c = 0; c < 4; c++) begin
            egress_pop = 1'b1;
            step(a);
        end
        egress_pop = 1'b0;
        chk("t3_refilled", 64'(credits_r), 64'd4);

        // Locked burst from src1 with competitors
        src_vld = 3'b111; src_lock = '0; egress_pop = 1'b1; done = 0; n = 0;
        for (int c = 0; c < 10 && n < 4; c++) begin
            src_lock[1] = (done < 2);
            step(a);
            if (a != '0) begin seq[n] = a; n++; end
            if (a[1]) begin done++; new_data(1); end
            if (n == 1 && a != '0) begin
                chk("t4_owner", 64'(lock_owner_r), 64'd1);
                chk("t4_lock_vld", 64'(lock_vld_r), 64'd1);
            end
        end
        chk("t4_seq0", 64'(seq[0]), 64'b010);
        chk("t4_seq1", 64'(seq[1]), 64'b010);
        chk("t4_seq2", 64'(seq[2]), 64'b010);
        chk("t4_seq3", 64'(seq[3]), 64'b100);
        src_vld = '0; src_lock = '0; egress_pop = 1'b0;
        step(a);

        // Locked burst running out of credits
        src_vld = 3'b111; done = 0;
        for (int c = 0; c < 30 && done < 6; c++) begin
            src_lock[0] = (done < 5);
            egress_pop  = (c >= 8);
            step(a);
            chk("t5_others_blocked", 64'(a & 3'b110), 64'd0);
            if (a[0]) begin done++; new_data(0); end
            if (c == 5) begin
                chk("t5_stall_lock", 64'(lock_vld_r), 64'd1);
                chk("t5_stall_credits", 64'(credits_r), 64'd0);
            end
        end
        chk("t5_burst_done", 64'(done), 64'd6);
        chk("t5_unlocked", 64'(lock_vld_r), 64'd0);
        src_vld = '0; src_lock = '0;
        for (int c = 0; c < 8; c++) begin
            egress_pop = (credits_r < CW'(C));
            step(a);
        end
        egress_pop = 1'b0;

        // Spurious credit return
        egress_pop = 1'b1;
        step(a);
        egress_pop = 1'b0;
        chk("t6_err_set", 64'(err_credit_r), 64'd1);
        chk("t6_credits_sat", 64'(credits_r), 64'd4);
        repeat (3) step(a);
        chk("t6_err_sticky", 64'(err_credit_r), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_cleared", 64'(err_credit_r), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic with bursts, stalls and a mid-run reset
        for (int i = 0; i < N; i++) left[i] = 0;
        a = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rst_n = 1'b0; src_vld = '0; src_lock = '0; egress_pop = 1'b0; a = '0;
                for (int i = 0; i < N; i++) left[i] = 0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (a[i]) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        src_vld[i] = 1'b0; src_lock[i] = 1'b0;
                    end else begin
                        new_data(i);
                        src_lock[i] = (left[i] > 1);
                        src_vld[i]  = ($urandom_range(3) != 0);
                    end
                end else if (!src_vld[i]) begin
                    if (left[i] > 0) begin
                        if ($urandom_range(1) == 1) src_vld[i] = 1'b1;
                    end else if ($urandom_range(2) == 0) begin
                        left[i] = ($urandom_range(3) == 0) ? int'($urandom_range(5, 2)) : 1;
                        src_lock[i] = (left[i] > 1);
                        new_data(i);
                        src_vld[i] = 1'b1;
                    end
                end
            end
            egress_pop = (credits_r < CW'(C)) && ($urandom_range(1) == 1);
            step(a);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
